// File: rtl/sparse_matrix_pkg.sv
// Shared definitions for the sparse-matrix entry joiner: default widths,
// the joined entry type and a pointer-width helper for the input FIFOs.
package sparse_matrix_pkg;

    localparam int unsigned IDX_WIDTH_DEF = 32;
    localparam int unsigned VAL_WIDTH_DEF = 64;

    // One joined matrix entry as seen by the SpMV stage.
    typedef struct packed {
        logic [IDX_WIDTH_DEF-1:0] row;
        logic [IDX_WIDTH_DEF-1:0] col;
        logic [VAL_WIDTH_DEF-1:0] val;
    } entry_t;

    // Pointer width with one extra wrap bit so full and empty differ.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sparse_matrix_entry_joiner_if.sv
// Decoder-side push/stall signals and the joined entry stream of the
// sparse-matrix entry joiner. The slave modport is the joiner itself.
interface sparse_matrix_entry_joiner_if
    import sparse_matrix_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = IDX_WIDTH_DEF,
    parameter int unsigned VAL_WIDTH = VAL_WIDTH_DEF
);
    logic                 push_index;
    logic [IDX_WIDTH-1:0] row;
    logic [IDX_WIDTH-1:0] col;
    logic                 stall_index;
    logic                 push_val;
    logic [VAL_WIDTH-1:0] val;
    logic                 stall_val;
    logic                 push_entry;
    logic [IDX_WIDTH-1:0] entry_row;
    logic [IDX_WIDTH-1:0] entry_col;
    logic [VAL_WIDTH-1:0] entry_val;
    logic                 entry_row_start;
    logic                 entry_last;
    logic                 stall_entry;

    modport master (
        output push_index, row, col, push_val, val, stall_entry,
        input  stall_index, stall_val, push_entry, entry_row, entry_col,
               entry_val, entry_row_start, entry_last
    );

    modport slave (
        input  push_index, row, col, push_val, val, stall_entry,
        output stall_index, stall_val, push_entry, entry_row, entry_col,
               entry_val, entry_row_start, entry_last
    );
endinterface

// File: rtl/sparse_matrix_entry_joiner_sync_fifo_stall.sv
// sync_fifo_stall: single-clock FIFO with wrap-bit pointers and a registered
// early-stall flag raised once occupancy reaches DEPTH-SLACK. A write while
// full is dropped and flagged on the overflow pulse output.
module sync_fifo_stall
    import sparse_matrix_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SLACK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             stall,
    output logic             overflow
);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   PW       = fifo_ptr_w(DEPTH);
    localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - SLACK);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    occ_d_s;
    logic             stall_q, stall_d;
    logic             full_s, empty_s, wr_acc_s, rd_acc_s;

    // Full/empty from the current pointers; the wrap bit separates the two.
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Next pointers and the stall flag for the resulting occupancy.
    always_comb begin
        wr_acc_s = wr_en && !full_s;
        rd_acc_s = rd_en && !empty_s;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d_s = wr_ptr_d - rd_ptr_d;
        if (occ_d_s >= STALL_TH) begin
            stall_d = 1'b1;
        end else begin
            stall_d = 1'b0;
        end
    end

    // Pointer and stall state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stall_q  <= stall_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign full     = full_s;
    assign empty    = empty_s;
    assign stall    = stall_q;
    assign overflow = wr_en && full_s;

endmodule

// File: rtl/sparse_matrix_entry_joiner.sv
// sparse_matrix_entry_joiner: buffers the decoder's index and value streams
// and joins them in order into registered (row, col, val) entries, marking
// row starts, counting against nnz and reporting busy/overflow.
// Optional macro SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN adds the
// sticky row_order_err output for non-increasing (row, col) order.
module sparse_matrix_entry_joiner
    import sparse_matrix_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STALL_SLACK = 4,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF,
    parameter int unsigned VAL_WIDTH   = VAL_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] nnz,
    output logic        busy,
    output logic        overflow,
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
    output logic        row_order_err,
`endif
    sparse_matrix_entry_joiner_if.slave bus
);
    logic [2*IDX_WIDTH-1:0] idx_rd_s;
    logic [VAL_WIDTH-1:0]   val_rd_s;
    logic [IDX_WIDTH-1:0]   pop_row_s, pop_col_s;
    logic idx_full_s, idx_empty_s, idx_stall_s, idx_ovf_s;
    logic val_full_s, val_empty_s, val_stall_s, val_ovf_s;
    logic pop_s;

    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 first_q, first_d;
    logic [63:0]          nnz_q, nnz_d;
    logic [63:0]          emit_count_q, emit_count_d;
    logic [IDX_WIDTH-1:0] last_row_q, last_row_d;
    logic                 push_entry_q, push_entry_d;
    logic [IDX_WIDTH-1:0] entry_row_q, entry_row_d;
    logic [IDX_WIDTH-1:0] entry_col_q, entry_col_d;
    logic [VAL_WIDTH-1:0] entry_val_q, entry_val_d;
    logic                 entry_row_start_q, entry_row_start_d;
    logic                 entry_last_q, entry_last_d;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
    logic [IDX_WIDTH-1:0] last_col_q, last_col_d;
    logic                 row_order_err_q, row_order_err_d;
    logic                 order_bad_s;
`endif

    sync_fifo_stall #(
        .WIDTH (2*IDX_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .SLACK (STALL_SLACK)
    ) u_idx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.push_index),
        .wr_data  ({bus.row, bus.col}),
        .rd_en    (pop_s),
        .rd_data  (idx_rd_s),
        .full     (idx_full_s),
        .empty    (idx_empty_s),
        .stall    (idx_stall_s),
        .overflow (idx_ovf_s)
    );

    sync_fifo_stall #(
        .WIDTH (VAL_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .SLACK (STALL_SLACK)
    ) u_val_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.push_val),
        .wr_data  (bus.val),
        .rd_en    (pop_s),
        .rd_data  (val_rd_s),
        .full     (val_full_s),
        .empty    (val_empty_s),
        .stall    (val_stall_s),
        .overflow (val_ovf_s)
    );

    // Join condition: both heads present, downstream ready, and entries left
    // in this matrix (so entries past nnz stay queued). No pop on start.
    always_comb begin
        pop_row_s = idx_rd_s[2*IDX_WIDTH-1:IDX_WIDTH];
        pop_col_s = idx_rd_s[IDX_WIDTH-1:0];
        if (busy_q && !start && !idx_empty_s && !val_empty_s &&
            !bus.stall_entry && (emit_count_q < nnz_q)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
    // An entry is out of order if its row goes backwards, or its column does
    // not advance within the same row.
    always_comb begin
        if (!first_q && ((pop_row_s < last_row_q) ||
            ((pop_row_s == last_row_q) && (pop_col_s <= last_col_q)))) begin
            order_bad_s = 1'b1;
        end else begin
            order_bad_s = 1'b0;
        end
    end
`endif

    // Next-state for the control flags, counters and registered entry.
    always_comb begin
        nnz_d             = nnz_q;
        emit_count_d      = emit_count_q;
        first_d           = first_q;
        last_row_d        = last_row_q;
        entry_row_d       = entry_row_q;
        entry_col_d       = entry_col_q;
        entry_val_d       = entry_val_q;
        push_entry_d      = pop_s;
        entry_row_start_d = 1'b0;
        entry_last_d      = 1'b0;
        busy_d            = busy_q;
        overflow_d        = overflow_q;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
        last_col_d        = last_col_q;
        row_order_err_d   = row_order_err_q;
`endif

        if (start) begin
            nnz_d        = nnz;
            emit_count_d = 64'd0;
            first_d      = 1'b1;
            busy_d       = (nnz != 64'd0);
            overflow_d   = 1'b0;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
            row_order_err_d = 1'b0;
`endif
        end else if (push_entry_q && entry_last_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        if (pop_s) begin
            entry_row_d       = pop_row_s;
            entry_col_d       = pop_col_s;
            entry_val_d       = val_rd_s;
            entry_row_start_d = first_q || (pop_row_s != last_row_q);
            entry_last_d      = ((emit_count_q + 64'd1) == nnz_q);
            emit_count_d      = emit_count_q + 64'd1;
            last_row_d        = pop_row_s;
            first_d           = 1'b0;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
            last_col_d        = pop_col_s;
            if (order_bad_s) begin
                row_order_err_d = 1'b1;
            end else begin
                row_order_err_d = row_order_err_q;
            end
`endif
        end else begin
            entry_row_start_d = 1'b0;
        end

        if (idx_ovf_s || val_ovf_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
    end

    // Register bank for control state and the outgoing entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nnz_q             <= 64'd0;
            emit_count_q      <= 64'd0;
            first_q           <= 1'b1;
            last_row_q        <= '0;
            busy_q            <= 1'b0;
            overflow_q        <= 1'b0;
            push_entry_q      <= 1'b0;
            entry_row_q       <= '0;
            entry_col_q       <= '0;
            entry_val_q       <= '0;
            entry_row_start_q <= 1'b0;
            entry_last_q      <= 1'b0;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
            last_col_q        <= '0;
            row_order_err_q   <= 1'b0;
`endif
        end else begin
            nnz_q             <= nnz_d;
            emit_count_q      <= emit_count_d;
            first_q           <= first_d;
            last_row_q        <= last_row_d;
            busy_q            <= busy_d;
            overflow_q        <= overflow_d;
            push_entry_q      <= push_entry_d;
            entry_row_q       <= entry_row_d;
            entry_col_q       <= entry_col_d;
            entry_val_q       <= entry_val_d;
            entry_row_start_q <= entry_row_start_d;
            entry_last_q      <= entry_last_d;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
            last_col_q        <= last_col_d;
            row_order_err_q   <= row_order_err_d;
`endif
        end
    end

`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
`ifndef SYNTHESIS
    // Simulation-only report of each out-of-order entry.
    always_ff @(posedge clk) begin
        if (rst_n && pop_s && order_bad_s) begin
            $display("row_order_err: row=%0d col=%0d", pop_row_s, pop_col_s);
        end
    end
`endif
    assign row_order_err = row_order_err_q;
`endif

    assign busy                = busy_q;
    assign overflow            = overflow_q;
    assign bus.stall_index     = idx_stall_s;
    assign bus.stall_val       = val_stall_s;
    assign bus.push_entry      = push_entry_q;
    assign bus.entry_row       = entry_row_q;
    assign bus.entry_col       = entry_col_q;
    assign bus.entry_val       = entry_val_q;
    assign bus.entry_row_start = entry_row_start_q;
    assign bus.entry_last      = entry_last_q;

endmodule

// File: tb/tb_sparse_matrix_entry_joiner.sv
// Self-checking bench for sparse_matrix_entry_joiner: expected entries are
// queued when pushed and compared by a monitor as the DUT emits them.
module tb_sparse_matrix_entry_joiner;
    import sparse_matrix_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] nnz = 64'd0;
    logic        busy, overflow;
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
    logic        row_order_err;
`endif

    sparse_matrix_entry_joiner_if #(.IDX_WIDTH(32), .VAL_WIDTH(64)) bus ();

    sparse_matrix_entry_joiner #(
        .FIFO_DEPTH(16), .STALL_SLACK(4), .IDX_WIDTH(32), .VAL_WIDTH(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .nnz      (nnz),
        .busy     (busy),
        .overflow (overflow),
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
        .row_order_err (row_order_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        logic        rs;
        logic        last;
    } exp_idx_t;

    exp_idx_t    exp_idx_q[$];
    logic [63:0] exp_val_q[$];
    int checks = 0;
    int failures = 0;
    int emit_total = 0;
    int first_emit_cyc = 0;
    int last_emit_cyc = 0;
    bit first_pending = 1'b0;
    bit wrap_done = 1'b0;

    logic [63:0] m_nnz = 64'd0;
    logic [63:0] m_cnt = 64'd0;
    bit          m_first = 1'b1;
    logic [31:0] m_last_row = 32'd0;

    // Scoreboard monitor: every emitted entry must match the oldest expected.
    always @(negedge clk) begin
        if (rst_n && bus.push_entry) begin
            exp_idx_t ei;
            logic [63:0] ev;
            emit_total++;
            last_emit_cyc = cyc;
            if (first_pending) begin
                first_emit_cyc = cyc;
                first_pending = 1'b0;
            end
            checks++;
            if (exp_idx_q.size() == 0 || exp_val_q.size() == 0) begin
                failures++;
                $display("FAIL entry_unexpected: got row=%0d col=%0d, required no entry", bus.entry_row, bus.entry_col);
            end else begin
                ei = exp_idx_q.pop_front();
                ev = exp_val_q.pop_front();
                if (bus.entry_row !== ei.row || bus.entry_col !== ei.col || bus.entry_val !== ev ||
                    bus.entry_row_start !== ei.rs || bus.entry_last !== ei.last) begin
                    failures++;
                    $display("FAIL entry_data: got (%0d,%0d,%h,rs=%b,last=%b) required (%0d,%0d,%h,rs=%b,last=%b)",
                             bus.entry_row, bus.entry_col, bus.entry_val, bus.entry_row_start, bus.entry_last,
                             ei.row, ei.col, ev, ei.rs, ei.last);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [63:0] n);
        start = 1'b1;
        nnz = n;
        m_nnz = n;
        m_cnt = 64'd0;
        m_first = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic q_idx(input logic [31:0] r, input logic [31:0] c);
        exp_idx_t e;
        e.row = r;
        e.col = c;
        e.rs = m_first || (r != m_last_row);
        e.last = ((m_cnt + 64'd1) == m_nnz);
        m_first = 1'b0;
        m_last_row = r;
        m_cnt = m_cnt + 64'd1;
        exp_idx_q.push_back(e);
    endtask

    task automatic push_pair(input logic [31:0] r, input logic [31:0] c, input logic [63:0] v, input bit expect_it);
        bus.push_index = 1'b1; bus.row = r; bus.col = c;
        bus.push_val = 1'b1; bus.val = v;
        if (expect_it) begin
            q_idx(r, c);
            exp_val_q.push_back(v);
        end
        @(posedge clk); #1;
        bus.push_index = 1'b0;
        bus.push_val = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_idx_q.size() != 0 || exp_val_q.size() != 0 || busy || bus.push_entry) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL idle_timeout: waited %0d cycles, required drain within %0d", n, budget);
        end
    endtask

    task automatic test_reset();
        bus.push_index = 1'b0; bus.push_val = 1'b0; bus.stall_entry = 1'b0;
        bus.row = 32'd0; bus.col = 32'd0; bus.val = 64'd0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, overflow, bus.push_entry, bus.entry_last, bus.entry_row_start, bus.stall_index, bus.stall_val} !== 7'd0 ||
            bus.entry_row !== 32'd0 || bus.entry_col !== 32'd0 || bus.entry_val !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b ovf=%b pe=%b row=%0d, required all zero", busy, overflow, bus.push_entry, bus.entry_row);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        // Mid-stream reset with three pairs held in the FIFOs.
        bus.stall_entry = 1'b1;
        do_start(64'd8);
        for (int i = 0; i < 3; i++) push_pair(32'(i), 32'(i), 64'(i + 100), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #4;
        checks++;
        if (bus.push_entry !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || bus.stall_index !== 1'b0) begin
            failures++;
            $display("FAIL midstream_reset: got pe=%b ovf=%b busy=%b stall=%b, required 0", bus.push_entry, overflow, busy, bus.stall_index);
        end
        rst_n = 1'b1;
        exp_idx_q.delete();
        exp_val_q.delete();
        bus.stall_entry = 1'b0;
        @(posedge clk); #1;
        // A fresh entry must come out first, proving the FIFOs were flushed.
        do_start(64'd1);
        push_pair(32'd7, 32'd9, 64'h0000_0000_0000_0777, 1'b1);
        wait_idle(50);
    endtask

    task automatic test_nnz_zero();
        do_start(64'd0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL nnz_zero_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic_join();
        logic [63:0] vals [4];
        int e0, push_cyc;
        bit seen = 1'b0;
        vals[0] = 64'h3FF0_0000_0000_0000;
        vals[1] = 64'h4000_0000_0000_0000;
        vals[2] = 64'h4008_0000_0000_0000;
        vals[3] = 64'h4010_0000_0000_0000;
        do_start(64'd4);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_start: got %b, required 1", busy);
        end
        e0 = emit_total;
        first_pending = 1'b1;
        push_cyc = cyc;
        push_pair(32'd0, 32'd1, vals[0], 1'b1);
        push_pair(32'd0, 32'd3, vals[1], 1'b1);
        push_pair(32'd2, 32'd0, vals[2], 1'b1);
        push_pair(32'd2, 32'd2, vals[3], 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.push_entry && bus.entry_last) begin
                seen = 1'b1;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy_at_last: got %b, required 1", busy);
                end
                @(posedge clk); #1;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_busy_after_last: got %b, required 0", busy);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL basic_last_timeout: got no entry_last, required one within 20 cycles");
        end
        checks++;
        if (first_emit_cyc !== push_cyc + 2 || last_emit_cyc - first_emit_cyc !== 3 || emit_total - e0 !== 4) begin
            failures++;
            $display("FAIL basic_timing: got first=%0d span=%0d count=%0d, required first=%0d span=3 count=4",
                     first_emit_cyc, last_emit_cyc - first_emit_cyc, emit_total - e0, push_cyc + 2);
        end
        wait_idle(20);
    endtask

    task automatic test_skewed();
        logic [31:0] rows [6];
        int e0, vcyc;
        rows[0] = 32'd1; rows[1] = 32'd1; rows[2] = 32'd1;
        rows[3] = 32'd4; rows[4] = 32'd4; rows[5] = 32'd5;
        do_start(64'd6);
        e0 = emit_total;
        for (int i = 0; i < 6; i++) begin
            bus.push_index = 1'b1; bus.row = rows[i]; bus.col = 32'(i * 3);
            q_idx(rows[i], 32'(i * 3));
            @(posedge clk); #1;
            bus.push_index = 1'b0;
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (emit_total !== e0) begin
            failures++;
            $display("FAIL skew_early_emit: got %0d entries, required 0 before values", emit_total - e0);
        end
        first_pending = 1'b1;
        vcyc = cyc;
        for (int i = 0; i < 6; i++) begin
            bus.push_val = 1'b1; bus.val = 64'(64'hABCD_0000 + i);
            exp_val_q.push_back(64'(64'hABCD_0000 + i));
            @(posedge clk); #1;
            bus.push_val = 1'b0;
        end
        wait_idle(50);
        checks++;
        if (first_emit_cyc !== vcyc + 2 || emit_total - e0 !== 6 || last_emit_cyc - first_emit_cyc !== 5) begin
            failures++;
            $display("FAIL skew_timing: got first=%0d count=%0d, required first=%0d count=6",
                     first_emit_cyc, emit_total - e0, vcyc + 2);
        end
    endtask

    task automatic test_back_pressure();
        int e0;
        bus.stall_entry = 1'b1;
        do_start(64'd16);
        e0 = emit_total;
        for (int k = 1; k <= 16; k++) begin
            push_pair(32'(k / 3), 32'(k), 64'(k * 11), 1'b1);
            checks++;
            if (bus.stall_index !== (k >= 12) || bus.stall_val !== (k >= 12)) begin
                failures++;
                $display("FAIL bp_stall_occ%0d: got idx=%b val=%b, required %b", k, bus.stall_index, bus.stall_val, (k >= 12));
            end
        end
        checks++;
        if (overflow !== 1'b0 || emit_total !== e0) begin
            failures++;
            $display("FAIL bp_before_extra: got ovf=%b emits=%0d, required ovf=0 emits=0", overflow, emit_total - e0);
        end
        push_pair(32'd99, 32'd99, 64'd99, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_overflow: got %b, required 1", overflow);
        end
        bus.stall_entry = 1'b0;
        wait_idle(100);
        checks++;
        if (emit_total - e0 !== 16 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain: got count=%0d ovf=%b, required count=16 ovf=1", emit_total - e0, overflow);
        end
    endtask

    task automatic test_wrap_around();
        int e0;
        do_start(64'd100);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ovf_cleared: got %b, required 0", overflow);
        end
        e0 = emit_total;
        wrap_done = 1'b0;
        fork
            begin
                fork
                    begin : idx_drv
                        logic [31:0] r = 32'd10;
                        for (int i = 0; i < 100; i++) begin
                            int guard = 0;
                            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                            while (bus.stall_index && guard < 2000) begin @(posedge clk); #1; guard++; end
                            r = r + 32'($urandom_range(0, 1));
                            bus.push_index = 1'b1; bus.row = r; bus.col = 32'(i);
                            q_idx(r, 32'(i));
                            @(posedge clk); #1;
                            bus.push_index = 1'b0;
                        end
                    end
                    begin : val_drv
                        for (int i = 0; i < 100; i++) begin
                            int guard = 0;
                            logic [63:0] v;
                            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                            while (bus.stall_val && guard < 2000) begin @(posedge clk); #1; guard++; end
                            v = {$urandom, $urandom};
                            bus.push_val = 1'b1; bus.val = v;
                            exp_val_q.push_back(v);
                            @(posedge clk); #1;
                            bus.push_val = 1'b0;
                        end
                    end
                join
                wrap_done = 1'b1;
            end
            begin : stall_drv
                while (!wrap_done) begin
                    bus.stall_entry = ($urandom_range(0, 3) == 0);
                    @(posedge clk); #1;
                end
                bus.stall_entry = 1'b0;
            end
        join
        wait_idle(3000);
        checks++;
        if (emit_total - e0 !== 100 || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_summary: got count=%0d ovf=%b busy=%b, required 100/0/0", emit_total - e0, overflow, busy);
        end
    endtask

`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
    task automatic test_row_order();
        int n = 0;
        do_start(64'd2);
        push_pair(32'd3, 32'd0, 64'd1, 1'b1);
        push_pair(32'd1, 32'd5, 64'd2, 1'b1);
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (bus.push_entry) begin
                n++;
                checks++;
                if (row_order_err !== (n == 2)) begin
                    failures++;
                    $display("FAIL row_order_emit%0d: got %b, required %b", n, row_order_err, (n == 2));
                end
            end
            @(posedge clk); #1;
        end
        wait_idle(20);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (row_order_err !== 1'b1) begin
            failures++;
            $display("FAIL row_order_sticky: got %b, required 1", row_order_err);
        end
        do_start(64'd0);
        checks++;
        if (row_order_err !== 1'b0) begin
            failures++;
            $display("FAIL row_order_clear: got %b, required 0", row_order_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nnz_zero();
        test_basic_join();
        test_skewed();
        test_back_pressure();
        test_wrap_around();
`ifdef SPARSE_MATRIX_ENTRY_JOINER_ROW_ORDER_CHECK_EN
        test_row_order();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
